raster_pixel_streamer: RTL

//  Reads a frame from a byte-wide frame-buffer RAM and emits it as a valid/ready RGB pixel stream.
//  - Frame layout: BMP bottom-up, 3 bytes/pixel, order B,G,R.
//  - Byte addr = WIDTH*3*(HEIGHT-1-y) + 3*x + ch.
//  - Output is in top-down raster order, with x/y coordinates and frame/line markers.
//  - Sits directly upstream of the crop/border stage, which consumes pix_x/pix_y against its left/right/top/bottom bounds.

---
 rtl/img_pkg.sv | 22 ++
 rtl/raster_addr_gen.sv | 66 ++++++
 rtl/raster_pixel_streamer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared constants and FSM encoding for the raster pixel streamer.
// Frame layout is BMP bottom-up, 3 bytes per pixel in B,G,R order.
package img_pkg;

    localparam int DEF_WIDTH       = 768;
    localparam int DEF_HEIGHT      = 512;
    localparam int BYTES_PER_PIXEL = 3;

    localparam int CH_B = 0;
    localparam int CH_G = 1;
    localparam int CH_R = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_B,
        ST_RD_G,
        ST_RD_R,
        ST_CAPT,
        ST_OUT
    } state_t;

endpackage

// File: rtl/raster_addr_gen.sv
// Top-down x/y raster counters and bottom-up frame-buffer pixel base address.
// Column offset is tracked as a running 3*x so no multiplier is needed.
module raster_addr_gen
    import img_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int ADDR_W  = 21,
    parameter int COORD_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_step,
    input  logic               i_reload,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic [ADDR_W-1:0]  o_pix_base,
    output logic               o_last
);

    localparam logic [ADDR_W-1:0] ROW_BYTES =
        ADDR_W'(WIDTH * BYTES_PER_PIXEL);
    localparam logic [ADDR_W-1:0] BASE_TOP =
        ADDR_W'(WIDTH * BYTES_PER_PIXEL * (HEIGHT - 1));
    localparam logic [ADDR_W-1:0] PIX_BYTES =
        ADDR_W'(BYTES_PER_PIXEL);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [ADDR_W-1:0]  r_row_base;
    logic [ADDR_W-1:0]  r_col_off;
    logic               w_eol;

    assign w_eol      = (r_x == X_MAX);
    assign o_last     = w_eol && (r_y == Y_MAX);
    assign o_x        = r_x;
    assign o_y        = r_y;
    assign o_pix_base = r_row_base + r_col_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= BASE_TOP;
            r_col_off  <= '0;
        end else if (i_reload || (i_step && o_last)) begin
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= BASE_TOP;
            r_col_off  <= '0;
        end else if (i_step) begin
            if (w_eol) begin
                r_x        <= '0;
                r_y        <= r_y + 1'b1;
                r_row_base <= r_row_base - ROW_BYTES;
                r_col_off  <= '0;
            end else begin
                r_x       <= r_x + 1'b1;
                r_col_off <= r_col_off + PIX_BYTES;
            end
        end
    end

endmodule

// File: rtl/raster_pixel_streamer.sv
// Reads B,G,R bytes per pixel from a 1-cycle sync RAM and presents them
// as a valid/ready RGB stream in top-down raster order with frame/line flags.
module raster_pixel_streamer
    import img_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int ADDR_W  = 21,
    parameter int COORD_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_rd_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [7:0]         pix_r,
    output logic [7:0]         pix_g,
    output logic [7:0]         pix_b,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_sof,
    output logic               pix_eol,
    output logic               pix_eof
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_hs;
    logic               w_reload;
    logic               w_last;
    logic [ADDR_W-1:0]  w_pix_base;
    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic               r_done;
    logic [7:0]         r_b;
    logic [7:0]         r_g;
    logic [7:0]         r_r;

    raster_addr_gen #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .ADDR_W  (ADDR_W),
        .COORD_W (COORD_W)
    ) u_addr (
        .clk        (clk),
        .rst        (rst),
        .i_step     (w_hs),
        .i_reload   (w_reload),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_pix_base (w_pix_base),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_hs && w_last;
        end
    end

    // Each capture takes the byte requested by the previous read state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b <= '0;
            r_g <= '0;
            r_r <= '0;
        end else begin
            if (r_state == ST_RD_G) r_b <= mem_rd_data;
            if (r_state == ST_RD_R) r_g <= mem_rd_data;
            if (r_state == ST_CAPT) r_r <= mem_rd_data;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        pix_valid = 1'b0;
        w_hs      = 1'b0;
        w_reload  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_RD_B;
            end
            ST_RD_B: begin
                mem_rd_en = 1'b1;
                mem_addr  = w_pix_base + ADDR_W'(CH_B);
                w_next    = ST_RD_G;
            end
            ST_RD_G: begin
                mem_rd_en = 1'b1;
                mem_addr  = w_pix_base + ADDR_W'(CH_G);
                w_next    = ST_RD_R;
            end
            ST_RD_R: begin
                mem_rd_en = 1'b1;
                mem_addr  = w_pix_base + ADDR_W'(CH_R);
                w_next    = ST_CAPT;
            end
            ST_CAPT: begin
                w_next = ST_OUT;
            end
            ST_OUT: begin
                pix_valid = 1'b1;
                w_hs      = pix_ready;
                if (pix_ready) w_next = w_last ? ST_IDLE : ST_RD_B;
            end
            default: w_next = ST_IDLE;
        endcase
        // Abort masks valid so downstream never sees a handshake it lost.
        if (abort && (r_state != ST_IDLE)) begin
            w_next    = ST_IDLE;
            w_reload  = 1'b1;
            w_hs      = 1'b0;
            pix_valid = 1'b0;
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign pix_b   = r_b;
    assign pix_g   = r_g;
    assign pix_r   = r_r;
    assign pix_x   = w_x;
    assign pix_y   = w_y;
    assign pix_sof = pix_valid && (w_x == '0) && (w_y == '0);
    assign pix_eol = pix_valid && (w_x == X_MAX);
    assign pix_eof = pix_valid && w_last;

endmodule
